// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter shared definitions.
// FU ids and defaults common to the write-back arbiter and CtrlUnit.
package wb_port_arbiter_pkg;

  localparam int NUM_FU_DEF = 5;
  localparam int XLEN_DEF   = 32;
  localparam int CNT_W_DEF  = 32;
  localparam int RD_W       = 5;

  typedef logic [2:0] fu_id_t;

  localparam fu_id_t FU_NONE = 3'd0;
  localparam fu_id_t FU_ALU  = 3'd1;
  localparam fu_id_t FU_MEM  = 3'd2;
  localparam fu_id_t FU_MUL  = 3'd3;
  localparam fu_id_t FU_DIV  = 3'd4;
  localparam fu_id_t FU_JUMP = 3'd5;

  function automatic fu_id_t fu_of_idx(input int idx);
    return fu_id_t'(idx + 1);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter bus bundle.
// FU result handover on one side, register-file write port on the other.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int XLEN   = XLEN_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic [NUM_FU-1:0]      res_valid;
  logic [NUM_FU-1:0]      res_we;
  logic [NUM_FU*RD_W-1:0] res_rd;
  logic [NUM_FU*XLEN-1:0] res_data;
  logic [NUM_FU-1:0]      res_ready;
  logic                   reg_write;
  logic [RD_W-1:0]        rd_ctrl;
  logic [XLEN-1:0]        wb_data;
  fu_id_t                 write_sel;
  logic [31:0]            pend_rd_mask;
  logic [CNT_W-1:0]       conflict_cnt;

  modport master (
    output res_valid, res_we, res_rd, res_data,
    input  res_ready, reg_write, rd_ctrl, wb_data,
    input  write_sel, pend_rd_mask, conflict_cnt
  );

  modport slave (
    input  res_valid, res_we, res_rd, res_data,
    output res_ready, reg_write, rd_ctrl, wb_data,
    output write_sel, pend_rd_mask, conflict_cnt
  );

endinterface

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// Generic N-way round-robin pick.
// Searches from ptr with wrap; ptr moves just past the winner.
module wb_port_arbiter_rr_arbiter #(
  parameter  int N     = 5,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W:0]   pos;

  // First requester at or after ptr, wrapping modulo N
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
      if (!gnt_any && req[pos[IDX_W-1:0]]) begin
        gnt_any                = 1'b1;
        gnt[pos[IDX_W-1:0]]    = 1'b1;
        gnt_idx                = pos[IDX_W-1:0];
      end
    end
  end

  // Pointer advances past the winner, holds when idle
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      if (gnt_idx == IDX_W'(N - 1)) ptr_d = '0;
      else                          ptr_d = gnt_idx + 1'b1;
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: one hold slot per FU,
// round-robin retire of one slot per cycle onto the RF write port.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int XLEN   = XLEN_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst,
  wb_port_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] hold_valid_q;
  logic [NUM_FU-1:0] hold_valid_d;
  logic [RD_W-1:0]   hold_rd_q   [NUM_FU];
  logic [RD_W-1:0]   hold_rd_d   [NUM_FU];
  logic [XLEN-1:0]   hold_data_q [NUM_FU];
  logic [XLEN-1:0]   hold_data_d [NUM_FU];

  logic              reg_write_q, reg_write_d;
  logic [RD_W-1:0]   rd_ctrl_q, rd_ctrl_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  fu_id_t            write_sel_q, write_sel_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic [NUM_FU-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] load;
  logic [31:0]       pend_rd_mask;
  logic              multi;

  wb_port_arbiter_rr_arbiter #(.N(NUM_FU)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (hold_valid_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Readiness and which handovers actually need a slot
  always_comb begin
    ready = ~hold_valid_q | gnt;
    load  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      load[i] = bus.res_valid[i] & ready[i] & bus.res_we[i]
              & (bus.res_rd[RD_W*i +: RD_W] != '0);
    end
  end

  // Slot update: retire the granted slot, reload if a result lands
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      hold_valid_d[i] = load[i] | (hold_valid_q[i] & ~gnt[i]);
      hold_rd_d[i]    = load[i] ? bus.res_rd[RD_W*i +: RD_W]
                                : hold_rd_q[i];
      hold_data_d[i]  = load[i] ? bus.res_data[XLEN*i +: XLEN]
                                : hold_data_q[i];
    end
  end

  // Write-back output select from the granted slot
  always_comb begin
    reg_write_d = gnt_any;
    write_sel_d = gnt_any ? fu_of_idx(int'(gnt_idx)) : FU_NONE;
    rd_ctrl_d   = '0;
    wb_data_d   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (gnt[i]) begin
        rd_ctrl_d = hold_rd_q[i];
        wb_data_d = hold_data_q[i];
      end
    end
  end

  // Pending-destination mask and saturating conflict counter
  always_comb begin
    pend_rd_mask = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (hold_valid_q[i]) pend_rd_mask[hold_rd_q[i]] = 1'b1;
    end
    pend_rd_mask[0] = 1'b0;
    multi = $countones(hold_valid_q) > 1;
    conflict_cnt_d = conflict_cnt_q;
    if (multi && (conflict_cnt_q != '1))
      conflict_cnt_d = conflict_cnt_q + 1'b1;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q   <= '0;
      reg_write_q    <= 1'b0;
      rd_ctrl_q      <= '0;
      wb_data_q      <= '0;
      write_sel_q    <= FU_NONE;
      conflict_cnt_q <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        hold_rd_q[i]   <= '0;
        hold_data_q[i] <= '0;
      end
    end else begin
      hold_valid_q   <= hold_valid_d;
      reg_write_q    <= reg_write_d;
      rd_ctrl_q      <= rd_ctrl_d;
      wb_data_q      <= wb_data_d;
      write_sel_q    <= write_sel_d;
      conflict_cnt_q <= conflict_cnt_d;
      for (int i = 0; i < NUM_FU; i++) begin
        hold_rd_q[i]   <= hold_rd_d[i];
        hold_data_q[i] <= hold_data_d[i];
      end
    end
  end

  assign bus.res_ready    = ready;
  assign bus.reg_write    = reg_write_q;
  assign bus.rd_ctrl      = rd_ctrl_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.write_sel    = write_sel_q;
  assign bus.pend_rd_mask = pend_rd_mask;
  assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus
// randomized traffic against a slot-level reference model.
module tb_wb_port_arbiter;

  localparam int N = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.NUM_FU(N), .XLEN(32), .CNT_W(32)) bus ();

  wb_port_arbiter #(.NUM_FU(N), .XLEN(32), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // FU offers: held stable until accepted
  logic        o_valid [N];
  logic        o_we    [N];
  logic [4:0]  o_rd    [N];
  logic [31:0] o_data  [N];

  // Reference model: held results, last winner, counter
  logic        m_valid [N];
  logic [4:0]  m_rd    [N];
  logic [31:0] m_data  [N];
  logic        m_acc   [N];
  int          m_last = N - 1;
  logic [31:0] m_cnt;
  logic        e_we;
  logic [4:0]  e_rd;
  logic [31:0] e_data;
  logic [2:0]  e_sel;

  function automatic int m_winner();
    for (int k = 1; k <= N; k++) begin
      int j = (m_last + k) % N;
      if (m_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int w = m_winner();
    for (int i = 0; i < N; i++) r[i] = !m_valid[i] || (i == w);
    return r;
  endfunction

  function automatic logic [31:0] exp_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < N; i++) if (m_valid[i]) m[m_rd[i]] = 1'b1;
    return m;
  endfunction

  task automatic model_edge();
    int w;
    int pc;
    logic [N-1:0] rdy;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 1'b0;
        m_acc[i] = 1'b0;
      end
      m_last = N - 1;
      m_cnt = '0;
      e_we = 1'b0; e_rd = '0; e_data = '0; e_sel = '0;
    end else begin
      w = m_winner();
      rdy = exp_ready();
      pc = 0;
      for (int i = 0; i < N; i++) pc += int'(m_valid[i]);
      if (pc >= 2 && m_cnt != '1) m_cnt = m_cnt + 1;
      if (w >= 0) begin
        e_we = 1'b1; e_rd = m_rd[w]; e_data = m_data[w];
        e_sel = 3'(w + 1);
        m_valid[w] = 1'b0;
        m_last = w;
      end else begin
        e_we = 1'b0; e_rd = '0; e_data = '0; e_sel = '0;
      end
      for (int i = 0; i < N; i++) begin
        m_acc[i] = o_valid[i] && rdy[i];
        if (m_acc[i] && o_we[i] && o_rd[i] != 5'd0) begin
          for (int j = 0; j < N; j++) begin
            if (j != i && m_valid[j] && m_rd[j] == o_rd[i]) begin
              miscompares++;
              $display("FAIL waw_guard fu=%0d rd=%0d also held by fu=%0d",
                       i, o_rd[i], j);
            end
          end
          m_valid[i] = 1'b1;
          m_rd[i] = o_rd[i];
          m_data[i] = o_data[i];
        end
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.res_valid[i] = o_valid[i];
      bus.res_we[i] = o_we[i];
      bus.res_rd[5*i +: 5] = o_rd[i];
      bus.res_data[32*i +: 32] = o_data[i];
    end
  endtask

  task automatic clear_offers();
    for (int i = 0; i < N; i++) begin
      o_valid[i] = 1'b0; o_we[i] = 1'b0;
      o_rd[i] = '0; o_data[i] = '0;
    end
  endtask

  task automatic tick();
    drive();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    if (rst) clear_offers();
    else for (int i = 0; i < N; i++) if (m_acc[i]) o_valid[i] = 1'b0;
  endtask

  task automatic offer(input int i, input logic we, input logic [4:0] rd,
                       input logic [31:0] d);
    o_valid[i] = 1'b1; o_we[i] = we; o_rd[i] = rd; o_data[i] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.reg_write !== 1'b0 || bus.write_sel !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_we_sel got=%0b/%0d want=0/0",
               bus.reg_write, bus.write_sel);
    end
    vectors++;
    if (bus.rd_ctrl !== 5'd0 || bus.wb_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_rd_data got=%0d/%h want=0/0",
               bus.rd_ctrl, bus.wb_data);
    end
    vectors++;
    if (bus.conflict_cnt !== 32'd0 || bus.pend_rd_mask !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_cnt_mask got=%0d/%h want=0/0",
               bus.conflict_cnt, bus.pend_rd_mask);
    end
    vectors++;
    if (bus.res_ready !== 5'b11111) begin
      miscompares++;
      $display("FAIL reset_ready got=%b want=11111", bus.res_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    offer(0, 1'b1, 5'd5, 32'h1234);
    vectors++;
    if (bus.res_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready got=%b want=1", bus.res_ready[0]);
    end
    tick();
    vectors++;
    if (bus.reg_write !== 1'b0 || bus.pend_rd_mask !== 32'h20) begin
      miscompares++;
      $display("FAIL single_held got=%0b/%h want=0/00000020",
               bus.reg_write, bus.pend_rd_mask);
    end
    tick();
    vectors++;
    if (bus.reg_write !== 1'b1 || bus.rd_ctrl !== 5'd5 ||
        bus.wb_data !== 32'h1234 || bus.write_sel !== 3'd1) begin
      miscompares++;
      $display("FAIL single_write got=%0b/%0d/%h/%0d want=1/5/1234/1",
               bus.reg_write, bus.rd_ctrl, bus.wb_data, bus.write_sel);
    end
    tick();
    vectors++;
    if (bus.reg_write !== 1'b0 || bus.write_sel !== 3'd0) begin
      miscompares++;
      $display("FAIL single_idle got=%0b/%0d want=0/0",
               bus.reg_write, bus.write_sel);
    end
  endtask

  task automatic test_contention();
    logic [2:0] want [3];
    want[0] = 3'd1; want[1] = 3'd3; want[2] = 3'd4;
    do_reset();
    offer(0, 1'b1, 5'd1, 32'hA1);
    offer(2, 1'b1, 5'd2, 32'hA3);
    offer(3, 1'b1, 5'd3, 32'hA4);
    vectors++;
    if (bus.res_ready[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL cont_div_ready got=%b want=1", bus.res_ready[3]);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (bus.reg_write !== 1'b1 || bus.write_sel !== want[k] ||
          bus.rd_ctrl !== 5'(k + 1)) begin
        miscompares++;
        $display("FAIL cont_order k=%0d got=%0b/%0d/%0d want=1/%0d/%0d",
                 k, bus.reg_write, bus.write_sel, bus.rd_ctrl,
                 want[k], k + 1);
      end
    end
    tick();
    vectors++;
    if (bus.conflict_cnt !== 32'd2 || bus.reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL cont_cnt got=%0d/%0b want=2/0",
               bus.conflict_cnt, bus.reg_write);
    end
  endtask

  task automatic test_fairness();
    int n0 = 0;
    int n1 = 0;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      if (!o_valid[0]) begin
        offer(0, 1'b1, 5'(8 + n0 % 8), $urandom);
        n0++;
      end
      if (!o_valid[1]) begin
        offer(1, 1'b1, 5'(16 + n1 % 8), $urandom);
        n1++;
      end
      tick();
      if (n >= 1) begin
        vectors++;
        if (bus.write_sel !== ((n % 2 == 1) ? 3'd1 : 3'd2) ||
            bus.wb_data !== e_data) begin
          miscompares++;
          $display("FAIL fair_sel n=%0d got=%0d/%h want=%0d/%h", n,
                   bus.write_sel, bus.wb_data,
                   (n % 2 == 1) ? 1 : 2, e_data);
        end
      end
    end
    clear_offers();
  endtask

  task automatic test_no_write();
    do_reset();
    offer(4, 1'b0, 5'd9, 32'hBEEF);
    vectors++;
    if (bus.res_ready[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL nowr_jump_ready got=%b want=1", bus.res_ready[4]);
    end
    tick();
    offer(1, 1'b1, 5'd0, 32'hCAFE);
    vectors++;
    if (bus.res_ready[1] !== 1'b1 || o_valid[4] !== 1'b0) begin
      miscompares++;
      $display("FAIL nowr_mem_ready got=%b jump_pending=%b want=1/0",
               bus.res_ready[1], o_valid[4]);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (bus.reg_write !== 1'b0 || bus.pend_rd_mask !== 32'd0) begin
        miscompares++;
        $display("FAIL nowr_quiet k=%0d got=%0b/%h want=0/0",
                 k, bus.reg_write, bus.pend_rd_mask);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    offer(0, 1'b1, 5'd4, 32'h0A);
    offer(2, 1'b1, 5'd7, 32'h0B);
    tick();
    offer(2, 1'b1, 5'd7, 32'h0C);
    vectors++;
    if (bus.res_ready[2] !== 1'b0 || bus.pend_rd_mask[7] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_stall got=%b/%b want=0/1",
               bus.res_ready[2], bus.pend_rd_mask[7]);
    end
    tick();
    vectors++;
    if (bus.write_sel !== 3'd1 || bus.rd_ctrl !== 5'd4 ||
        bus.res_ready[2] !== 1'b1 || bus.pend_rd_mask[7] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_grant got=%0d/%0d/%b/%b want=1/4/1/1",
               bus.write_sel, bus.rd_ctrl, bus.res_ready[2],
               bus.pend_rd_mask[7]);
    end
    tick();
    vectors++;
    if (bus.write_sel !== 3'd3 || bus.wb_data !== 32'h0B ||
        bus.pend_rd_mask !== 32'h80) begin
      miscompares++;
      $display("FAIL bp_reload got=%0d/%h/%h want=3/0b/00000080",
               bus.write_sel, bus.wb_data, bus.pend_rd_mask);
    end
    tick();
    vectors++;
    if (bus.write_sel !== 3'd3 || bus.rd_ctrl !== 5'd7 ||
        bus.wb_data !== 32'h0C) begin
      miscompares++;
      $display("FAIL bp_second got=%0d/%0d/%h want=3/7/0c",
               bus.write_sel, bus.rd_ctrl, bus.wb_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    offer(0, 1'b1, 5'd11, 32'h11);
    offer(1, 1'b1, 5'd12, 32'h12);
    offer(2, 1'b1, 5'd13, 32'h13);
    tick();
    vectors++;
    if (bus.pend_rd_mask !== 32'h3800) begin
      miscompares++;
      $display("FAIL rmid_mask got=%h want=00003800", bus.pend_rd_mask);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.pend_rd_mask !== 32'd0 || bus.reg_write !== 1'b0 ||
        bus.conflict_cnt !== 32'd0 || bus.res_ready !== 5'b11111) begin
      miscompares++;
      $display("FAIL rmid_state got=%h/%0b/%0d/%b want=0/0/0/11111",
               bus.pend_rd_mask, bus.reg_write, bus.conflict_cnt,
               bus.res_ready);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (bus.reg_write !== 1'b0) begin
        miscompares++;
        $display("FAIL rmid_stale k=%0d got=%0b want=0", k, bus.reg_write);
      end
    end
  endtask

  function automatic logic rd_free(input logic [4:0] rd, input int self);
    for (int j = 0; j < N; j++) begin
      if (m_valid[j] && m_rd[j] == rd) return 1'b0;
      if (j != self && o_valid[j] && o_we[j] && o_rd[j] == rd) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic new_offer(input int i);
    logic [4:0] cand;
    o_valid[i] = 1'b1;
    o_data[i] = $urandom;
    o_we[i] = ($urandom_range(0, 9) != 0);
    o_rd[i] = '0;
    if ($urandom_range(0, 9) != 0) begin
      o_we[i] = 1'b0;
      for (int t = 0; t < 64; t++) begin
        cand = 5'($urandom_range(1, 31));
        if (rd_free(cand, i)) begin
          o_rd[i] = cand;
          o_we[i] = ($urandom_range(0, 9) != 0);
          break;
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      if (!rst)
        for (int i = 0; i < N; i++)
          if (!o_valid[i] && $urandom_range(0, 99) < 45) new_offer(i);
      vectors++;
      if (bus.res_ready !== exp_ready() ||
          bus.pend_rd_mask !== exp_mask()) begin
        miscompares++;
        $display("FAIL rnd_ready n=%0d got=%b/%h want=%b/%h", n,
                 bus.res_ready, bus.pend_rd_mask, exp_ready(), exp_mask());
      end
      tick();
      vectors++;
      if (bus.reg_write !== e_we || bus.rd_ctrl !== e_rd ||
          bus.wb_data !== e_data || bus.write_sel !== e_sel) begin
        miscompares++;
        $display("FAIL rnd_wb n=%0d got=%0b/%0d/%h/%0d want=%0b/%0d/%h/%0d",
                 n, bus.reg_write, bus.rd_ctrl, bus.wb_data, bus.write_sel,
                 e_we, e_rd, e_data, e_sel);
      end
      vectors++;
      if (bus.conflict_cnt !== m_cnt) begin
        miscompares++;
        $display("FAIL rnd_cnt n=%0d got=%0d want=%0d",
                 n, bus.conflict_cnt, m_cnt);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    clear_offers();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_acc[i] = 1'b0;
      m_rd[i] = '0; m_data[i] = '0;
    end
    m_cnt = '0;
    drive();
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_no_write();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
